// File: rtl/hash_pe_request_compactor.sv
// hash_pe_request_compactor
//   Packs the masked slots of one hash-request vector into up to OUT_LANES
//   output lanes per cycle, lowest slot index first. A per-vector cap keeps
//   only the lowest cfg_max_req requests; the rest are counted as dropped.
//   A vector that cannot be fully emitted in its acceptance cycle is parked
//   in a one-vector buffer and drained from there (in_ready low meanwhile).
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_max_req       per-vector request cap (0 or >ISSUE_W = unlimited)
//   in_valid/in_ready input vector handshake
//   in_head_addr      address of slot 0
//   in_mask           slot-valid mask
//   in_hash_vec       per-slot hash values, slot i at [i*HASH_W +: HASH_W]
//   in_delim          vector delimiter
//   out_valid         contiguous lane-valid mask
//   out_addr_vec      per-lane address (head + slot index, wrapping)
//   out_hash_vec      per-lane hash value
//   out_last          lane carrying the final kept request of its vector
//   out_delim         delimiter of the vector being emitted
//   out_ready         accepts all valid lanes at once
//   in_flush_mode     high while draining the buffer
//   dropped_cnt       saturating count of capped-away requests
module hash_pe_request_compactor #(
  parameter int unsigned ISSUE_W   = 8,
  parameter int unsigned OUT_LANES = 2,
  parameter int unsigned HASH_W    = 13,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1,
  localparam int unsigned CW       = IDX_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CW-1:0]               cfg_max_req,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_head_addr,
  input  logic [ISSUE_W-1:0]          in_mask,
  input  logic [HASH_W*ISSUE_W-1:0]   in_hash_vec,
  input  logic                        in_delim,
  output logic [OUT_LANES-1:0]        out_valid,
  output logic [ADDR_W*OUT_LANES-1:0] out_addr_vec,
  output logic [HASH_W*OUT_LANES-1:0] out_hash_vec,
  output logic [OUT_LANES-1:0]        out_last,
  output logic                        out_delim,
  input  logic                        out_ready,
  output logic                        in_flush_mode,
  output logic [CNT_W-1:0]            dropped_cnt
);

  localparam int unsigned SUM_W = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b01,
    ST_DRAIN  = 2'b10
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           buf_head_q;
  logic [HASH_W*ISSUE_W-1:0]   buf_hash_q;
  logic                        buf_delim_q;
  logic [ISSUE_W-1:0]          buf_mask_q, buf_mask_d;
  logic                        buf_load;
  logic [CNT_W-1:0]            dropped_q, dropped_d;

  logic [CW-1:0]               cap;
  logic [ISSUE_W-1:0]          kept_mask;
  logic [CW-1:0]               in_cnt, kept_cnt, drop_cnt;
  logic [SUM_W-1:0]            drop_sum;

  logic                        is_drain;
  logic [ISSUE_W-1:0]          src_mask;
  logic [ADDR_W-1:0]           src_head;
  logic [HASH_W*ISSUE_W-1:0]   src_hash;
  logic [ISSUE_W-1:0]          emit_mask;
  logic [CW-1:0]               pend_cnt;
  logic [CW-1:0]               pre [ISSUE_W];
  logic [IDX_W-1:0]            lane_idx [OUT_LANES];
  logic                        lane_on;

  // Effective cap and the kept subset (lowest `cap` set bits) of the input mask
  always_comb begin
    cap       = ((cfg_max_req == '0) || (cfg_max_req > CW'(ISSUE_W))) ? CW'(ISSUE_W) : cfg_max_req;
    kept_mask = '0;
    in_cnt    = '0;
    kept_cnt  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (in_mask[i]) begin
        in_cnt = in_cnt + CW'(1);
        if (kept_cnt < cap) begin
          kept_mask[i] = 1'b1;
          kept_cnt     = kept_cnt + CW'(1);
        end
      end
    end
    drop_cnt = in_cnt - kept_cnt;
    drop_sum = SUM_W'(dropped_q) + SUM_W'(drop_cnt);
  end

  // Lanes come from the buffer while draining, otherwise straight from the input
  assign is_drain = (state_q == ST_DRAIN);
  assign src_mask = is_drain ? buf_mask_q  : kept_mask;
  assign src_head = is_drain ? buf_head_q  : in_head_addr;
  assign src_hash = is_drain ? buf_hash_q  : in_hash_vec;

  // Prefix count of pending bits: slot i goes to lane pre[i] if that lane exists
  always_comb begin
    emit_mask = '0;
    pend_cnt  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      pre[i] = pend_cnt;
      if (src_mask[i]) begin
        if (pend_cnt < CW'(OUT_LANES)) emit_mask[i] = 1'b1;
        pend_cnt = pend_cnt + CW'(1);
      end
    end
  end

  // Slot index feeding each lane
  always_comb begin
    for (int j = 0; j < OUT_LANES; j++) begin
      lane_idx[j] = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
        if (src_mask[i] && (pre[i] == CW'(j))) lane_idx[j] = IDX_W'(i);
      end
    end
  end

  // Output lanes; everything handshake-related is forced low during reset.
  // The highest kept request is always the highest pending one, so the last
  // lane is the one whose position equals the remaining pending count.
  always_comb begin
    lane_on       = !rst && (is_drain || ((state_q == ST_NORMAL) && in_valid));
    in_ready      = !rst && (state_q == ST_NORMAL);
    in_flush_mode = !rst && is_drain;
    out_delim     = is_drain ? buf_delim_q : in_delim;
    out_valid     = '0;
    out_last      = '0;
    out_addr_vec  = '0;
    out_hash_vec  = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      out_valid[j] = lane_on && (CW'(j) < pend_cnt);
      out_last[j]  = lane_on && (pend_cnt == CW'(j + 1));
      out_addr_vec[j*ADDR_W +: ADDR_W] = src_head + ADDR_W'(lane_idx[j]);
      out_hash_vec[j*HASH_W +: HASH_W] = src_hash[int'(lane_idx[j])*HASH_W +: HASH_W];
    end
  end

  // Next-state, buffer mask and drop counter
  always_comb begin
    state_d    = state_q;
    buf_mask_d = buf_mask_q;
    buf_load   = 1'b0;
    dropped_d  = dropped_q;
    case (state_q)
      ST_NORMAL: begin
        if (in_valid) begin
          dropped_d = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(drop_sum);
          if ((kept_cnt != '0) && !(out_ready && (kept_cnt <= CW'(OUT_LANES)))) begin
            state_d    = ST_DRAIN;
            buf_load   = 1'b1;
            buf_mask_d = out_ready ? (kept_mask & ~emit_mask) : kept_mask;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          buf_mask_d = buf_mask_q & ~emit_mask;
          if (buf_mask_d == '0) state_d = ST_NORMAL;
        end
      end
      default: begin
        state_d    = ST_NORMAL;
        buf_mask_d = '0;
      end
    endcase
  end

  // State, buffer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      buf_mask_q  <= '0;
      buf_head_q  <= '0;
      buf_hash_q  <= '0;
      buf_delim_q <= 1'b0;
      dropped_q   <= '0;
    end else begin
      state_q    <= state_d;
      buf_mask_q <= buf_mask_d;
      dropped_q  <= dropped_d;
      if (buf_load) begin
        buf_head_q  <= in_head_addr;
        buf_hash_q  <= in_hash_vec;
        buf_delim_q <= in_delim;
      end
    end
  end

  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_hash_pe_request_compactor.sv
// Directed bench for hash_pe_request_compactor (ISSUE_W=8, OUT_LANES=2,
// CNT_W=4 so counter saturation is reachable in a few vectors).
module tb_hash_pe_request_compactor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_max_req;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_head_addr;
  logic [7:0]  in_mask;
  logic [103:0] in_hash_vec;
  logic        in_delim;
  logic [1:0]  out_valid;
  logic [63:0] out_addr_vec;
  logic [25:0] out_hash_vec;
  logic [1:0]  out_last;
  logic        out_delim;
  logic        out_ready;
  logic        in_flush_mode;
  logic [3:0]  dropped_cnt;

  int passed = 0;
  int total  = 0;

  hash_pe_request_compactor #(
    .ISSUE_W(8), .OUT_LANES(2), .HASH_W(13), .ADDR_W(32), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_max_req(cfg_max_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_head_addr(in_head_addr),
    .in_mask(in_mask), .in_hash_vec(in_hash_vec), .in_delim(in_delim),
    .out_valid(out_valid), .out_addr_vec(out_addr_vec), .out_hash_vec(out_hash_vec),
    .out_last(out_last), .out_delim(out_delim), .out_ready(out_ready),
    .in_flush_mode(in_flush_mode), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [7:0] m, input logic [31:0] h, input logic d);
    in_valid     = 1'b1;
    in_mask      = m;
    in_head_addr = h;
    in_delim     = d;
  endtask

  // Check both lanes: valid, last, addresses
  task automatic chk_lanes(input string tag, input logic [1:0] v, input logic [1:0] l,
                           input logic [31:0] a0, input logic [31:0] a1);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".last"},  64'(out_last),  64'(l));
    if (v[0]) chk({tag, ".addr0"}, 64'(out_addr_vec[31:0]),  64'(a0));
    if (v[1]) chk({tag, ".addr1"}, 64'(out_addr_vec[63:32]), 64'(a1));
  endtask

  initial begin
    rst = 1'b1; cfg_max_req = 4'd0; in_valid = 1'b0; in_head_addr = '0;
    in_mask = '0; in_delim = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_hash_vec[i*13 +: 13] = 13'(13'h1A0 + i);

    // Reset: outputs quiet even with a valid vector presented
    step();
    drive_vec(8'hFF, 32'h0, 1'b0);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.out_last", 64'(out_last), 64'(0));
    chk("rst.flush", 64'(in_flush_mode), 64'(0));
    chk("rst.dropped", 64'(dropped_cnt), 64'(0));
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("idle.in_ready", 64'(in_ready), 64'(1));

    // 1: mask 1011_0110, uncapped, 3 beats
    drive_vec(8'b1011_0110, 32'h100, 1'b1);
    #1;
    chk_lanes("t1.c0", 2'b11, 2'b00, 32'h101, 32'h102);
    chk("t1.c0.hash0", 64'(out_hash_vec[12:0]), 64'(13'h1A1));
    chk("t1.c0.hash1", 64'(out_hash_vec[25:13]), 64'(13'h1A2));
    chk("t1.c0.delim", 64'(out_delim), 64'(1));
    step();
    in_valid = 1'b0; in_delim = 1'b0;
    #1;
    chk("t1.c1.in_ready", 64'(in_ready), 64'(0));
    chk("t1.c1.flush", 64'(in_flush_mode), 64'(1));
    chk("t1.c1.delim", 64'(out_delim), 64'(1));
    chk_lanes("t1.c1", 2'b11, 2'b00, 32'h104, 32'h105);
    step();
    chk_lanes("t1.c2", 2'b01, 2'b01, 32'h107, 32'h0);
    chk("t1.c2.hash0", 64'(out_hash_vec[12:0]), 64'(13'h1A7));
    step();
    chk("t1.end.in_ready", 64'(in_ready), 64'(1));
    chk("t1.end.flush", 64'(in_flush_mode), 64'(0));
    chk("t1.end.valid", 64'(out_valid), 64'(0));
    chk("t1.end.dropped", 64'(dropped_cnt), 64'(0));

    // 2: same vector capped at 3 -> 0x101,0x102 then 0x104 last, 2 dropped
    cfg_max_req = 4'd3;
    drive_vec(8'b1011_0110, 32'h100, 1'b0);
    #1;
    chk_lanes("t2.c0", 2'b11, 2'b00, 32'h101, 32'h102);
    step();
    in_valid = 1'b0;
    #1;
    chk_lanes("t2.c1", 2'b01, 2'b01, 32'h104, 32'h0);
    chk("t2.c1.dropped", 64'(dropped_cnt), 64'(2));
    step();
    chk("t2.end.in_ready", 64'(in_ready), 64'(1));

    // 3: single request at the top of the address space, no DRAIN
    cfg_max_req = 4'd0;
    drive_vec(8'b0000_0001, 32'hFFFF_FFFF, 1'b0);
    #1;
    chk_lanes("t3.c0", 2'b01, 2'b01, 32'hFFFF_FFFF, 32'h0);
    chk("t3.c0.in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    #1;
    chk("t3.c1.in_ready", 64'(in_ready), 64'(1));
    chk("t3.c1.flush", 64'(in_flush_mode), 64'(0));

    // 3b: slot 7 off a wrapping head
    drive_vec(8'b1000_0001, 32'hFFFF_FFFE, 1'b0);
    #1;
    chk_lanes("t3b.c0", 2'b11, 2'b10, 32'hFFFF_FFFE, 32'h0000_0005);
    step();
    in_valid = 1'b0;

    // 4: full mask with back-pressure for 3 cycles, then 4 drain beats
    out_ready = 1'b0;
    drive_vec(8'hFF, 32'h200, 1'b1);
    #1;
    chk_lanes("t4.c0", 2'b11, 2'b00, 32'h200, 32'h201);
    step();
    in_valid = 1'b0;
    cfg_max_req = 4'd1;
    #1;
    chk("t4.c1.in_ready", 64'(in_ready), 64'(0));
    chk_lanes("t4.c1", 2'b11, 2'b00, 32'h200, 32'h201);
    step();
    chk_lanes("t4.c2", 2'b11, 2'b00, 32'h200, 32'h201);
    chk("t4.c2.delim", 64'(out_delim), 64'(1));
    out_ready = 1'b1;
    step();
    chk_lanes("t4.b1", 2'b11, 2'b00, 32'h202, 32'h203);
    step();
    chk_lanes("t4.b2", 2'b11, 2'b00, 32'h204, 32'h205);
    step();
    chk_lanes("t4.b3", 2'b11, 2'b10, 32'h206, 32'h207);
    chk("t4.b3.hash1", 64'(out_hash_vec[25:13]), 64'(13'h1A7));
    step();
    chk("t4.end.in_ready", 64'(in_ready), 64'(1));
    chk("t4.end.dropped", 64'(dropped_cnt), 64'(2));
    cfg_max_req = 4'd0;

    // 5: reset while draining
    drive_vec(8'hFF, 32'h300, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("t5.drain.flush", 64'(in_flush_mode), 64'(1));
    step();
    rst = 1'b1;
    #1;
    chk("t5.rst.valid", 64'(out_valid), 64'(0));
    chk("t5.rst.flush", 64'(in_flush_mode), 64'(0));
    step();
    chk("t5.rst2.valid", 64'(out_valid), 64'(0));
    chk("t5.rst2.flush", 64'(in_flush_mode), 64'(0));
    chk("t5.rst2.dropped", 64'(dropped_cnt), 64'(0));
    rst = 1'b0;
    drive_vec(8'b0000_0011, 32'h400, 1'b0);
    #1;
    chk_lanes("t5.new", 2'b11, 2'b10, 32'h400, 32'h401);
    step();
    in_valid = 1'b0;
    #1;
    chk("t5.after.valid", 64'(out_valid), 64'(0));
    chk("t5.after.flush", 64'(in_flush_mode), 64'(0));

    // 6: empty mask consumed silently, then counter saturation at 15
    drive_vec(8'h00, 32'h500, 1'b1);
    #1;
    chk("t6.empty.valid", 64'(out_valid), 64'(0));
    chk("t6.empty.in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    #1;
    chk("t6.empty.after_ready", 64'(in_ready), 64'(1));
    chk("t6.empty.dropped", 64'(dropped_cnt), 64'(0));
    cfg_max_req = 4'd1;
    drive_vec(8'hFF, 32'h600, 1'b0);
    #1;
    chk_lanes("t6.cap1", 2'b01, 2'b01, 32'h600, 32'h0);
    step();
    step();
    in_valid = 1'b0;
    #1;
    chk("t6.dropped14", 64'(dropped_cnt), 64'(14));
    drive_vec(8'b0000_1111, 32'h700, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("t6.dropped_sat", 64'(dropped_cnt), 64'(15));
    drive_vec(8'b0000_0011, 32'h700, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("t6.dropped_hold", 64'(dropped_cnt), 64'(15));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
